// File: rtl/bus_deser_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bus_deser_pkg
// Description : Shared phase codes, FSM state encoding and defaults for the
//               pad-bus deserializer.
// Revision    : 1.0 - initial release
// ============================================================================
package bus_deser_pkg;

  localparam logic [1:0] LH_ADL = 2'd0;
  localparam logic [1:0] LH_ADH = 2'd1;
  localparam logic [1:0] LH_SDO = 2'd2;
  localparam logic [1:0] LH_ILL = 2'd3;

  localparam logic [2:0] ST_WAIT_ADL = 3'd0;
  localparam logic [2:0] ST_WAIT_ADH = 3'd1;
  localparam logic [2:0] ST_MEM_RD   = 3'd2;
  localparam logic [2:0] ST_WAIT_SDO = 3'd3;
  localparam logic [2:0] ST_MEM_WR   = 3'd4;
  localparam logic [2:0] ST_PULSE    = 3'd5;

  localparam int unsigned DEF_TIMEOUT_CYCLES = 255;
  localparam logic [7:0]  DEF_RDATA_ABORT    = 8'hFF;

  typedef enum logic [1:0] {
    PH_IGNORE  = 2'd0,
    PH_CAPTURE = 2'd1,
    PH_ERROR   = 2'd2
  } phase_act_e;

  // The serializer keeps showing the previous phase until it sees rdy, so
  // the code just behind the awaited one is benign; anything else is an error.
  function automatic phase_act_e classify_phase(input logic [2:0] state,
                                                input logic [1:0] lh);
    logic [1:0] want;
    logic [1:0] stale;
    logic       waiting;
    waiting = 1'b1;
    want    = LH_ADL;
    stale   = LH_ADH;
    case (state)
      ST_WAIT_ADL: begin want = LH_ADL; stale = LH_ADH; end
      ST_WAIT_ADH: begin want = LH_ADH; stale = LH_ADL; end
      ST_WAIT_SDO: begin want = LH_SDO; stale = LH_ADH; end
      default:     waiting = 1'b0;
    endcase
    if (!waiting || lh == stale) return PH_IGNORE;
    if (lh == want) return PH_CAPTURE;
    return PH_ERROR;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bus_watchdog.sv
`default_nettype none
// ============================================================================
// Module      : bus_watchdog
// Description : Memory-ack watchdog; counts cycles while start is high and
//               flags expiry in the TIMEOUT_CYCLES-th cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module bus_watchdog
  import bus_deser_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic reset_n,
  input  logic start,
  input  logic clear,
  output logic expired
);

  localparam int unsigned c_cnt_w = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(TIMEOUT_CYCLES - 1);

  logic [c_cnt_w-1:0] r_count;
  logic               w_at_last;

  assign w_at_last = (r_count == c_last);
  assign expired   = start & w_at_last;

  // Saturates at the last value; the owner drops start on expiry anyway.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (start && !w_at_last) begin
      r_count <= r_count + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/bus_deserializer.sv
`default_nettype none
// ============================================================================
// Module      : bus_deserializer
// Description : Rebuilds address/write data from the multiplexed pad bus and
//               runs one memory transaction per bus cycle. Optional memory-ack
//               watchdog enabled by defining BUS_DESER_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module bus_deserializer
  import bus_deser_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter logic [7:0]  RDATA_ABORT    = DEF_RDATA_ABORT
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [7:0]  pad_in,
  input  logic [1:0]  lh,
  input  logic        we_pad,
  output logic        rdy,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic        mem_ack,
  input  logic [7:0]  mem_rdata,
  output logic [7:0]  di,
  output logic        di_valid,
  output logic        proto_err
);

  logic [2:0]  r_state;
  logic [2:0]  r_after_pulse;
  logic        r_rdy;
  logic        r_mem_req;
  logic        r_mem_we;
  logic [15:0] r_mem_addr;
  logic [7:0]  r_mem_wdata;
  logic [7:0]  r_di;
  logic        r_di_valid;
  logic        r_proto_err;

  phase_act_e  w_act;
  logic        w_ack;
  logic        w_expired;
  logic        w_mem_done;

  assign w_act      = classify_phase(r_state, lh);
  assign w_ack      = r_mem_req & mem_ack;
  assign w_mem_done = w_ack | w_expired;

`ifdef BUS_DESER_TIMEOUT_EN
  logic w_wd_clear;

  assign w_wd_clear = ~r_mem_req;

  bus_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (r_mem_req),
    .clear   (w_wd_clear),
    .expired (w_expired)
  );
`else
  logic w_unused_cfg;

  assign w_expired    = 1'b0;
  assign w_unused_cfg = (TIMEOUT_CYCLES == 0);
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= ST_WAIT_ADL;
      r_after_pulse <= ST_WAIT_ADL;
      r_rdy         <= 1'b0;
      r_mem_req     <= 1'b0;
      r_mem_we      <= 1'b0;
      r_mem_addr    <= '0;
      r_mem_wdata   <= '0;
      r_di          <= '0;
      r_di_valid    <= 1'b0;
      r_proto_err   <= 1'b0;
    end else begin
      r_rdy      <= 1'b0;
      r_di_valid <= 1'b0;
      case (r_state)
        ST_WAIT_ADL: begin
          if (w_act == PH_CAPTURE) begin
            r_mem_addr[7:0] <= pad_in;
            r_rdy           <= 1'b1;
            r_state         <= ST_PULSE;
            r_after_pulse   <= ST_WAIT_ADH;
          end else if (w_act == PH_ERROR) begin
            r_proto_err <= 1'b1;
          end
        end
        ST_WAIT_ADH: begin
          if (w_act == PH_CAPTURE) begin
            r_mem_addr[15:8] <= pad_in;
            r_mem_we         <= we_pad;
            if (we_pad) begin
              r_rdy         <= 1'b1;
              r_state       <= ST_PULSE;
              r_after_pulse <= ST_WAIT_SDO;
            end else begin
              // Reads are paced by the memory, so no rdy until the ack.
              r_mem_req <= 1'b1;
              r_state   <= ST_MEM_RD;
            end
          end else if (w_act == PH_ERROR) begin
            r_proto_err <= 1'b1;
            r_state     <= ST_WAIT_ADL;
          end
        end
        ST_WAIT_SDO: begin
          if (w_act == PH_CAPTURE) begin
            r_mem_wdata <= pad_in;
            r_mem_req   <= 1'b1;
            r_state     <= ST_MEM_WR;
          end else if (w_act == PH_ERROR) begin
            r_proto_err <= 1'b1;
            r_state     <= ST_WAIT_ADL;
          end
        end
        ST_MEM_RD, ST_MEM_WR: begin
          if (w_mem_done) begin
            r_mem_req     <= 1'b0;
            r_rdy         <= 1'b1;
            r_state       <= ST_PULSE;
            r_after_pulse <= ST_WAIT_ADL;
            if (r_state == ST_MEM_RD) begin
              r_di       <= w_ack ? mem_rdata : RDATA_ABORT;
              r_di_valid <= 1'b1;
            end
            if (!w_ack) begin
              r_proto_err <= 1'b1;
            end
          end
        end
        ST_PULSE: begin
          r_state <= r_after_pulse;
        end
        default: begin
          r_state <= ST_WAIT_ADL;
        end
      endcase
    end
  end

  assign rdy       = r_rdy;
  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign di        = r_di;
  assign di_valid  = r_di_valid;
  assign proto_err = r_proto_err;

endmodule
`default_nettype wire
